// File: rtl/loop_responder_pkg.sv
// Shared types and default parameters for the loop responder slice.
package loop_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 32'sd2;
    localparam int DEF_DEPTH  = 32'sd4;
    localparam int DEF_SEQ_W  = 32'sd4;

endpackage

// File: rtl/loop_fifo.sv
// First-word-fall-through buffer with registered storage and occupancy count.
// The caller guarantees no push when full and no pop when empty.
module loop_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Entry storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/loop_responder.sv
// Responder leg of a valid/ready loop: returns ~req_data tagged with a wrapping sequence number.
// Optional LOOP_RESPONDER_PARITY_EN adds rsp_parity (even parity of the head entry).
module loop_responder
    import loop_responder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SEQ_W  = DEF_SEQ_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [SEQ_W-1:0]  rsp_seq,
`ifdef LOOP_RESPONDER_PARITY_EN
    output logic              rsp_parity,
`endif
    output logic              busy
);

    localparam int ENTRY_W = DATA_W + SEQ_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   next_count_s;
    logic [SEQ_W-1:0]   seq_r;
    state_t             state_r;
    logic               req_ready_r;
    logic               rsp_valid_r;
    logic               busy_r;

    assign push_s = req_valid & req_ready_r;
    assign pop_s  = rsp_valid_r & rsp_ready;

    loop_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   ({~req_data, seq_r}),
        .pop   (pop_s),
        .dout  (head_s),
        .count (count_s)
    );

    // Occupancy after this cycle's handshakes; drives all registered status.
    always_comb begin
        next_count_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Sequence tag advances once per accepted request, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_r <= {SEQ_W{1'b0}};
        end else if (push_s) begin
            seq_r <= seq_r + SEQ_W'(1);
        end
    end

    // Occupancy FSM with registered handshake and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= (next_count_s == {CNT_W{1'b0}}) ? IDLE : RUN;
                end
                RUN: begin
                    if (next_count_s == {CNT_W{1'b0}}) begin
                        state_r <= IDLE;
                    end else if (next_count_s == CNT_W'(DEPTH)) begin
                        state_r <= FULL;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FULL: begin
                    state_r <= (next_count_s == CNT_W'(DEPTH)) ? FULL : RUN;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            req_ready_r <= (next_count_s != CNT_W'(DEPTH));
            rsp_valid_r <= (next_count_s != {CNT_W{1'b0}});
            busy_r      <= (next_count_s != {CNT_W{1'b0}});
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;
    assign rsp_data  = head_s[ENTRY_W-1:SEQ_W];
    assign rsp_seq   = head_s[SEQ_W-1:0];

`ifdef LOOP_RESPONDER_PARITY_EN
    function automatic logic even_parity(input logic [ENTRY_W-1:0] v);
        return ^v;
    endfunction

    assign rsp_parity = rsp_valid_r & even_parity(head_s);
`endif

endmodule

// File: tb/tb_loop_responder.sv
// Self-checking bench for loop_responder: directed steps plus random traffic against a queue model.
module tb_loop_responder;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
    localparam int SEQ_W  = 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [SEQ_W-1:0]  rsp_seq;
    logic              busy;
`ifdef LOOP_RESPONDER_PARITY_EN
    logic              rsp_parity;
`endif

    int vectors;
    int miscompares;

    // Reference model: queue of expected {data, seq} responses and the next tag.
    logic [DATA_W+SEQ_W-1:0] q [$];
    int                      model_seq;

    loop_responder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SEQ_W  (SEQ_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_seq    (rsp_seq),
`ifdef LOOP_RESPONDER_PARITY_EN
        .rsp_parity (rsp_parity),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DATA_W-1:0] hd;
        logic [SEQ_W-1:0]  hs;
        chk({tag, ".req_ready"}, 8'(req_ready), 8'(q.size() < DEPTH));
        chk({tag, ".rsp_valid"}, 8'(rsp_valid), 8'(q.size() != 0));
        chk({tag, ".busy"},      8'(busy),      8'(q.size() != 0));
        if (q.size() != 0) begin
            hd = q[0][DATA_W+SEQ_W-1:SEQ_W];
            hs = q[0][SEQ_W-1:0];
            chk({tag, ".rsp_data"}, 8'(rsp_data), 8'(hd));
            chk({tag, ".rsp_seq"},  8'(rsp_seq),  8'(hs));
`ifdef LOOP_RESPONDER_PARITY_EN
            chk({tag, ".rsp_parity"}, 8'(rsp_parity), 8'(^{hd, hs}));
        end else begin
            chk({tag, ".rsp_parity"}, 8'(rsp_parity), 8'd0);
`endif
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".req_ready"}, 8'(req_ready), 8'd1);
        chk({tag, ".rsp_valid"}, 8'(rsp_valid), 8'd0);
        chk({tag, ".busy"},      8'(busy),      8'd0);
        chk({tag, ".rsp_data"},  8'(rsp_data),  8'd0);
        chk({tag, ".rsp_seq"},   8'(rsp_seq),   8'd0);
`ifdef LOOP_RESPONDER_PARITY_EN
        chk({tag, ".rsp_parity"}, 8'(rsp_parity), 8'd0);
`endif
    endtask

    // One clock of traffic: drive, check before the edge, then advance the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, input string tag);
        logic do_push;
        logic do_pop;
        req_valid = v;
        req_data  = d;
        rsp_ready = r;
        @(negedge clk);
        check_outputs(tag);
        do_push = v && (q.size() < DEPTH);
        do_pop  = r && (q.size() != 0);
        @(posedge clk);
        if (do_pop) begin
            void'(q.pop_front());
        end
        if (do_push) begin
            q.push_back({~d, SEQ_W'(model_seq)});
            model_seq = (model_seq + 1) % (1 << SEQ_W);
        end
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_seq   = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_data    = 2'b00;
        rsp_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        step(1'b0, 2'b00, 1'b0, "idle");
        step(1'b0, 2'b00, 1'b0, "idle2");

        // Single request / response.
        step(1'b1, 2'b01, 1'b0, "single_acc");
        step(1'b0, 2'b00, 1'b1, "single_rsp");
        step(1'b0, 2'b00, 1'b0, "single_idle");

        // Fill with backpressure: fifth request must wait.
        step(1'b1, 2'b00, 1'b0, "fill0");
        step(1'b1, 2'b01, 1'b0, "fill1");
        step(1'b1, 2'b10, 1'b0, "fill2");
        step(1'b1, 2'b11, 1'b0, "fill3");
        step(1'b1, 2'b00, 1'b0, "fill_full");
        step(1'b1, 2'b00, 1'b1, "full_pop");
        step(1'b1, 2'b00, 1'b1, "drain1");
        step(1'b0, 2'b00, 1'b1, "drain2");
        step(1'b0, 2'b00, 1'b1, "drain3");
        step(1'b0, 2'b00, 1'b1, "drain4");
        step(1'b0, 2'b00, 1'b1, "drain5");
        step(1'b0, 2'b00, 1'b0, "drained");

        // Concurrent push/pop at two entries, then hold under backpressure.
        step(1'b1, 2'b10, 1'b0, "conc_a");
        step(1'b1, 2'b01, 1'b0, "conc_b");
        step(1'b1, 2'b11, 1'b1, "conc_pp");
        step(1'b0, 2'b00, 1'b0, "conc_hold1");
        step(1'b0, 2'b00, 1'b0, "conc_hold2");
        step(1'b0, 2'b00, 1'b1, "conc_d1");
        step(1'b0, 2'b00, 1'b1, "conc_d2");
        step(1'b0, 2'b00, 1'b0, "conc_end");

        // Sequence wrap over 17 request/response pairs.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, DATA_W'(i), 1'b0, "wrap_req");
            step(1'b0, 2'b00, 1'b1, "wrap_rsp");
        end
        step(1'b0, 2'b00, 1'b0, "wrap_end");

        // Asynchronous reset between edges with three entries buffered.
        step(1'b1, 2'b01, 1'b0, "mr0");
        step(1'b1, 2'b10, 1'b0, "mr1");
        step(1'b1, 2'b11, 1'b0, "mr2");
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        q.delete();
        model_seq = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 2'b01, 1'b0, "post_rst0");
        step(1'b1, 2'b00, 1'b1, "post_rst1");
        step(1'b0, 2'b00, 1'b0, "parity_seq1");
        step(1'b0, 2'b00, 1'b1, "post_rst_drain");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 3) != 0), "rand");
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'b00, 1'b1, "final_drain");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
